immediate_pipe: RTL and testbench
=================================

# immediate_pipe

Pipelined, multi-lane RISC-V immediate generator for the decode stage. Each accepted beat carries `LANES` 32-bit instruction words with per-lane format selects. The block extracts and sign-extends each immediate to `XLEN`. It registers the result behind a valid/ready handshake with a two-entry skid buffer, so decode-to-execute backpressure never drops a beat.

## Interface
- `LANES`, 1: instructions per beat, 1..4.
- `XLEN`, 32: output immediate width, 32 or 64.
- `TAG_W`, 4: width of the sideband tag carried alongside each beat.
- `I_clk`  in  1  single clock, rising edge.
- `I_rstn`  in  1  reset, asynchronous, active-low.
- `I_flush`  in  1  synchronous pipeline flush.
- `I_valid`  in  1  input beat valid.
- `O_ready`  out  1  block can accept a beat; registered.
- `I_immsel`  in  3*LANES  format select per lane; lane k uses bits [3k+2:3k].
- `I_data`  in  32*LANES  instruction words; lane k uses bits [32k+31:32k].
- `I_tag`  in  TAG_W  sideband tag.
- `O_valid`  out  1  output beat valid.
- `I_ready`  in  1  downstream accepts the output beat.
- `O_data`  out  XLEN*LANES  immediates; lane k uses bits [XLEN*k+XLEN-1:XLEN*k].
- `O_illegal`  out  LANES  per-lane flag: the select was unsupported.
- `O_tag`  out  TAG_W  tag of the output beat.

## Operation
- Select encodings:
  - `IMM_ITYPE`=0: inst[31:20].
  - `IMM_STYPE`=1: {inst[31:25], inst[11:7]}.
  - `IMM_BTYPE`=2: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - `IMM_UTYPE`=3: {inst[31:12], 12'b0}.
  - `IMM_JTYPE`=4: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - `IMM_ZTYPE`=5: zero-extended inst[19:15]. Valid only when the configuration macro is defined.
- Width rules:
  - All formats except Z sign-extend from inst[31] to `XLEN`.
  - U-type at `XLEN`=64 also sign-extends bits 63:32 from inst[31].
- Unsupported select (6, 7, or 5 without the macro): lane data is all-zero and `O_illegal[k]`=1. Other lanes are unaffected.
- Storage: output register OUT and skid register SKID. Each holds data, illegal flags, tag and a valid bit.
- State (occupancy): EMPTY (neither valid), ONE (OUT valid), FULL (OUT and SKID valid).
- Transitions (`acc` = `I_valid & O_ready`, `drn` = `O_valid & I_ready`):
  - EMPTY: `acc` -> ONE.
  - ONE:
    - `acc & !drn` -> FULL (beat goes to SKID).
    - `acc & drn` -> ONE (OUT is replaced).
    - `!acc & drn` -> EMPTY.
  - FULL:
    - `drn` -> ONE (SKID moves to OUT).
    - No accept is possible, since `O_ready`=0.
- `O_ready` = state != FULL, computed from the registered state.
- `O_valid` = OUT valid bit. `O_data`/`O_illegal`/`O_tag` hold steady while `O_valid & !I_ready`.
- Flush:
  - `I_flush`=1 forces EMPTY on the next edge.
  - It overrides any accept or drain in the same cycle; the beat presented that cycle is discarded.
- Reset:
  - `I_rstn` low asynchronously forces EMPTY.
  - Output values during reset: `O_valid`=0, `O_ready`=0, `O_data`=0, `O_illegal`=0, `O_tag`=0.
  - `O_ready` rises on the first clock edge after `I_rstn` deasserts.
  - Reset mid-transfer drops all held beats.

## Timing
- Latency: input beat accepted at edge N -> `O_valid` with its data after edge N (available in cycle N+1).
- Throughput: one beat per cycle while `I_ready` stays high.
- Stall:
  - On the first cycle `I_ready` is low with OUT valid, one further beat is accepted into SKID.
  - `O_ready` falls the cycle after that.
- Release: the first `drn` in FULL moves SKID to OUT; `O_ready` rises the following cycle.
- Ordering is strict FIFO. No combinational path from `I_ready` to `O_ready`.

## Configuration
- `IMMGEN_ZTYPE_EN` defined: select 5 produces the CSR zimm, {XLEN-5 zeros, inst[19:15]}, with `O_illegal`=0.
- Not defined: select 5 is treated as unsupported (zero data, `O_illegal`=1). The Z-type extraction logic is absent.

## Test plan
- Format check: `LANES`=1, `XLEN`=32, inst 0x00208463, selects 0..4 -> `O_data` 0x00000002, 0x00000008, 0x00000008, 0x00208000, 0x00008002 respectively, each one cycle after accept.
- Sign extension and Z-type:
  - inst 0xFFF00093, select 0, `XLEN`=64 -> 0xFFFFFFFFFFFFFFFF.
  - Select 5 on inst 0x00208463 -> 0x1 with `IMMGEN_ZTYPE_EN` defined.
  - Without the macro -> 0 with `O_illegal`=1.
- Multi-lane and illegal: `LANES`=4, selects {7,2,0,3}, all lanes inst 0x00208463 -> lanes 0x00208000, 0x00000002, 0x00000008, 0.
  - `O_illegal`=4'b1000.
  - `O_tag` equals the input tag.
- Backpressure: stream tags 1..6 continuously; hold `I_ready` low for 4 cycles after tag 1 appears.
  - Tag 2 lands in SKID and `O_ready` drops one cycle later.
  - After release, tags 1..6 emerge in order with no loss or duplication.
- Flush and reset:
  - In FULL, assert `I_flush` with `I_valid`=1 -> next cycle `O_valid`=0, `O_ready`=1, and the beat is discarded.
  - Pulse `I_rstn` low mid-stream -> outputs zero immediately (asynchronously); `O_ready` returns after the first post-reset edge.

Source files
------------

// File: rtl/immediate_pipe.sv
// immediate_pipe: multi-lane RISC-V immediate generator feeding a two-entry (OUT + SKID) output stage.
// Define IMMGEN_ZTYPE_EN to decode select 5 as the CSR zimm; without it select 5 is flagged illegal.
module immediate_pipe #(
  parameter int LANES = 1,
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                    I_clk,
  input  logic                    I_rstn,
  input  logic                    I_flush,
  input  logic                    I_valid,
  output logic                    O_ready,
  input  logic [3*LANES-1:0]      I_immsel,
  input  logic [32*LANES-1:0]     I_data,
  input  logic [TAG_W-1:0]        I_tag,
  output logic                    O_valid,
  input  logic                    I_ready,
  output logic [XLEN*LANES-1:0]   O_data,
  output logic [LANES-1:0]        O_illegal,
  output logic [TAG_W-1:0]        O_tag,
  output logic [1:0]              O_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [2:0] IMM_ITYPE = 3'd0;
  localparam logic [2:0] IMM_STYPE = 3'd1;
  localparam logic [2:0] IMM_BTYPE = 3'd2;
  localparam logic [2:0] IMM_UTYPE = 3'd3;
  localparam logic [2:0] IMM_JTYPE = 3'd4;
`ifdef IMMGEN_ZTYPE_EN
  localparam logic [2:0] IMM_ZTYPE = 3'd5;
`endif

  // Returns {illegal, immediate}; unsupported selects yield a zero immediate.
  function automatic logic [XLEN:0] gen_imm(input logic [31:0] inst, input logic [2:0] sel);
    logic [XLEN-1:0] sx;
    logic [XLEN:0]   r;
    sx = {XLEN{inst[31]}};
    r  = '0;
    case (sel)
      IMM_ITYPE: r = {1'b0, sx[XLEN-1:12], inst[31:20]};
      IMM_STYPE: r = {1'b0, sx[XLEN-1:12], inst[31:25], inst[11:7]};
      IMM_BTYPE: r = {1'b0, sx[XLEN-1:13], inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_UTYPE: begin
        r       = {1'b0, sx};
        r[31:0] = {inst[31:12], 12'b0};
      end
      IMM_JTYPE: r = {1'b0, sx[XLEN-1:21], inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`ifdef IMMGEN_ZTYPE_EN
      IMM_ZTYPE: r = {1'b0, {(XLEN-5){1'b0}}, inst[19:15]};
`endif
      default:   r = {1'b1, {XLEN{1'b0}}};
    endcase
    return r;
  endfunction

  logic [XLEN*LANES-1:0] dec_data;
  logic [LANES-1:0]      dec_ill;

  always_comb begin
    dec_data = '0;
    dec_ill  = '0;
    for (int k = 0; k < LANES; k++) begin
      {dec_ill[k], dec_data[XLEN*k +: XLEN]} = gen_imm(I_data[32*k +: 32], I_immsel[3*k +: 3]);
    end
  end

  state_t                state;
  logic                  ready_q;
  logic                  out_v;
  logic [XLEN*LANES-1:0] out_data;
  logic [LANES-1:0]      out_ill;
  logic [TAG_W-1:0]      out_tag;
  logic                  skid_v;
  logic [XLEN*LANES-1:0] skid_data;
  logic [LANES-1:0]      skid_ill;
  logic [TAG_W-1:0]      skid_tag;

  // Handshake: a beat moves on an edge where its valid and the matching ready are both high;
  // valid never waits on ready, and O_ready comes only from registered state.
  logic acc;
  logic drn;
  assign acc = I_valid & ready_q;
  assign drn = out_v & I_ready;

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state     <= ST_EMPTY;
      ready_q   <= 1'b0;
      out_v     <= 1'b0;
      out_data  <= '0;
      out_ill   <= '0;
      out_tag   <= '0;
      skid_v    <= 1'b0;
      skid_data <= '0;
      skid_ill  <= '0;
      skid_tag  <= '0;
    end else if (I_flush) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
      out_v   <= 1'b0;
      skid_v  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            out_data <= dec_data;
            out_ill  <= dec_ill;
            out_tag  <= I_tag;
            out_v    <= 1'b1;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && !drn) begin
            skid_data <= dec_data;
            skid_ill  <= dec_ill;
            skid_tag  <= I_tag;
            skid_v    <= 1'b1;
            state     <= ST_FULL;
            ready_q   <= 1'b0;
          end else if (acc) begin
            out_data <= dec_data;
            out_ill  <= dec_ill;
            out_tag  <= I_tag;
          end else if (drn) begin
            out_v <= 1'b0;
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drn) begin
            out_data <= skid_data;
            out_ill  <= skid_ill;
            out_tag  <= skid_tag;
            out_v    <= skid_v;
            skid_v   <= 1'b0;
            state    <= ST_ONE;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_EMPTY;
          out_v  <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

  assign O_ready   = ready_q;
  assign O_valid   = out_v;
  assign O_data    = out_data;
  assign O_illegal = out_ill;
  assign O_tag     = out_tag;
  assign O_state   = state;

endmodule

// File: tb/tb_immediate_pipe.sv
// Bench for immediate_pipe (LANES=4, XLEN=64): queue-based reference model plus directed literal checks.
// Honours IMMGEN_ZTYPE_EN the same way the design does.
module tb_immediate_pipe;
  localparam int LANES = 4;
  localparam int XLEN  = 64;
  localparam int TAG_W = 4;
  localparam int EW    = TAG_W + LANES + XLEN*LANES;

  logic                  I_clk = 1'b0;
  logic                  I_rstn = 1'b1;
  logic                  I_flush = 1'b0;
  logic                  I_valid = 1'b0;
  logic                  O_ready;
  logic [3*LANES-1:0]    I_immsel = '0;
  logic [32*LANES-1:0]   I_data = '0;
  logic [TAG_W-1:0]      I_tag = '0;
  logic                  O_valid;
  logic                  I_ready = 1'b1;
  logic [XLEN*LANES-1:0] O_data;
  logic [LANES-1:0]      O_illegal;
  logic [TAG_W-1:0]      O_tag;
  logic [1:0]            O_state;

  immediate_pipe #(.LANES(LANES), .XLEN(XLEN), .TAG_W(TAG_W)) u_dut (
    .I_clk(I_clk), .I_rstn(I_rstn), .I_flush(I_flush), .I_valid(I_valid), .O_ready(O_ready),
    .I_immsel(I_immsel), .I_data(I_data), .I_tag(I_tag), .O_valid(O_valid), .I_ready(I_ready),
    .O_data(O_data), .O_illegal(O_illegal), .O_tag(O_tag), .O_state(O_state)
  );

  // clock / reset
  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference immediate computed with signed arithmetic shifts and masks.
  function automatic void ref_imm(input logic [31:0] inst, input logic [2:0] sel,
                                  output logic [63:0] imm, output logic ill);
    longint s, u, t12, t20, t25, t31;
    s   = $signed(inst);
    u   = longint'({32'b0, inst});
    t12 = s >>> 12;
    t20 = s >>> 20;
    t25 = s >>> 25;
    t31 = s >>> 31;
    imm = '0;
    ill = 1'b0;
    case (sel)
      3'd0: imm = t20;
      3'd1: imm = (t25 << 5) | ((u >> 7) & 64'h1f);
      3'd2: imm = (t31 << 12) | (((u >> 7) & 64'h1) << 11) | (((u >> 25) & 64'h3f) << 5)
                  | (((u >> 8) & 64'hf) << 1);
      3'd3: imm = t12 << 12;
      3'd4: imm = (t31 << 20) | (((u >> 12) & 64'hff) << 12) | (((u >> 20) & 64'h1) << 11)
                  | (((u >> 21) & 64'h3ff) << 1);
`ifdef IMMGEN_ZTYPE_EN
      3'd5: imm = (u >> 15) & 64'h1f;
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [EW-1:0] model_beat(input logic [3*LANES-1:0] sel,
                                               input logic [32*LANES-1:0] d,
                                               input logic [TAG_W-1:0] tag);
    logic [XLEN*LANES-1:0] data;
    logic [LANES-1:0]      ill;
    logic [63:0]           v;
    logic                  il;
    data = '0;
    ill  = '0;
    for (int k = 0; k < LANES; k++) begin
      ref_imm(d[32*k +: 32], sel[3*k +: 3], v, il);
      data[XLEN*k +: XLEN] = v;
      ill[k] = il;
    end
    return {tag, ill, data};
  endfunction

  // scoreboard: queue of beats held in the block, oldest at the front
  logic [EW-1:0]    exp_q[$];
  logic [TAG_W-1:0] tag_log[$];
  bit               live = 1'b0;

  always @(posedge I_clk or negedge I_rstn) begin
    bit acc, drn;
    if (!I_rstn) begin
      exp_q.delete();
      live = 1'b0;
    end else begin
      acc = I_valid && live && (exp_q.size() < 2);
      drn = (exp_q.size() > 0) && I_ready;
      if (I_flush) begin
        exp_q.delete();
      end else begin
        if (drn) begin
          tag_log.push_back(exp_q[0][EW-1 -: TAG_W]);
          void'(exp_q.pop_front());
        end
        if (acc) exp_q.push_back(model_beat(I_immsel, I_data, I_tag));
      end
      live = 1'b1;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge I_clk) begin
    if (!I_rstn) begin
      check("rst_o_valid", O_valid, 0);
      check("rst_o_ready", O_ready, 0);
      check("rst_o_beat", {O_tag, O_illegal, O_data}, 0);
    end else begin
      check("o_valid", O_valid, exp_q.size() != 0);
      check("o_ready", O_ready, live && (exp_q.size() < 2));
      if (exp_q.size() != 0) check("o_beat", {O_tag, O_illegal, O_data}, exp_q[0]);
    end
  end

  // driver tasks
  task automatic send(input logic [3*LANES-1:0] sel, input logic [32*LANES-1:0] d,
                      input logic [TAG_W-1:0] tag);
    int n = 0;
    I_valid  = 1'b1;
    I_immsel = sel;
    I_data   = d;
    I_tag    = tag;
    while (!O_ready && n < 50) begin
      @(posedge I_clk); #2;
      n++;
    end
    if (!O_ready) check("send_timeout", 0, 1);
    @(posedge I_clk); #2;
    I_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge I_clk); #2;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  logic [31:0] inst_tab [6] = '{32'h00208463, 32'hFFF00093, 32'h80000537,
                                32'hFE5FF06F, 32'hFEB50CE3, 32'h7FF00113};
  logic [15:0] rdy_pat = 16'b1011_0011_1101_0110;
  logic [63:0] fmt_exp [5] = '{64'h2, 64'h8, 64'h8, 64'h00208000, 64'h00008002};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 I_rstn = 1'b0;
    repeat (2) @(posedge I_clk);
    #2;
    check("reset_ready_low", O_ready, 0);
    check("reset_valid_low", O_valid, 0);
    I_rstn = 1'b1;
    @(posedge I_clk); #2;
    check("ready_after_reset", O_ready, 1);

    // format check on lane 0
    for (int k = 0; k < 5; k++) begin
      send({9'b0, 3'(k)}, {96'b0, 32'h00208463}, 4'(k));
      check("fmt_data", O_data[63:0], fmt_exp[k]);
      check("fmt_illegal", O_illegal, 0);
    end

    // sign extension and Z-type
    send(12'd0, {96'b0, 32'hFFF00093}, 4'h5);
    check("sext_i", O_data[63:0], 64'hFFFFFFFFFFFFFFFF);
    send(12'd5, {96'b0, 32'h00208463}, 4'h6);
`ifdef IMMGEN_ZTYPE_EN
    check("ztype_data", O_data[63:0], 64'h1);
    check("ztype_illegal", O_illegal, 4'b0000);
`else
    check("ztype_data", O_data[63:0], 64'h0);
    check("ztype_illegal", O_illegal, 4'b0001);
`endif

    // multi-lane with one illegal lane
    send({3'd7, 3'd2, 3'd0, 3'd3}, {4{32'h00208463}}, 4'hA);
    check("lanes_data", O_data, {64'h0, 64'h8, 64'h2, 64'h00208000});
    check("lanes_illegal", O_illegal, 4'b1000);
    check("lanes_tag", O_tag, 4'hA);
    wait_drain("drain_directed");

    // backpressure: tags 1..6 streamed, I_ready low for 4 cycles once tag 1 shows
    tag_log.delete();
    fork
      begin
        for (int t = 1; t <= 6; t++) send({4{3'(t % 5)}}, {4{inst_tab[t % 6]}}, 4'(t));
      end
      begin
        int n = 0;
        while (!(O_valid && O_tag == 4'd1) && n < 40) begin
          @(negedge I_clk);
          n++;
        end
        check("bp_tag1_seen", O_tag, 1);
        I_ready = 1'b0;
        @(negedge I_clk);
        check("bp_ready_low", O_ready, 0);
        check("bp_full", O_state, 2'd2);
        check("bp_out_tag", O_tag, 1);
        repeat (3) @(negedge I_clk);
        I_ready = 1'b1;
      end
    join
    wait_drain("drain_bp");
    check("bp_count", tag_log.size(), 6);
    for (int i = 0; i < 6 && i < tag_log.size(); i++) check("bp_order", tag_log[i], i + 1);

    // table-driven stream with a fixed ready pattern
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [3*LANES-1:0]  sel;
          logic [32*LANES-1:0] d;
          for (int k = 0; k < LANES; k++) begin
            sel[3*k +: 3] = 3'((i + 3*k) % 8);
            d[32*k +: 32] = inst_tab[(i + k) % 6];
          end
          send(sel, d, 4'(i));
        end
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge I_clk); #1;
          I_ready = rdy_pat[c % 16];
        end
        I_ready = 1'b1;
      end
    join
    wait_drain("drain_table");

    // flush while FULL with a beat presented
    I_ready = 1'b0;
    send(12'd0, {4{32'hFFF00093}}, 4'h1);
    send(12'd3, {4{32'h80000537}}, 4'h2);
    check("flush_pre_full", O_state, 2'd2);
    I_valid = 1'b1;
    I_flush = 1'b1;
    I_tag   = 4'h3;
    @(posedge I_clk); #2;
    I_valid = 1'b0;
    I_flush = 1'b0;
    check("flush_valid", O_valid, 0);
    check("flush_ready", O_ready, 1);
    I_ready = 1'b1;
    repeat (3) @(negedge I_clk);
    check("flush_discard", O_valid, 0);

    // asynchronous reset mid-stream
    send(12'd4, {4{32'hFE5FF06F}}, 4'h9);
    I_ready  = 1'b0;
    I_valid  = 1'b1;
    I_tag    = 4'hB;
    @(posedge I_clk); #3;
    I_rstn = 1'b0;
    #1;
    check("arst_valid", O_valid, 0);
    check("arst_ready", O_ready, 0);
    check("arst_data", O_data, 0);
    check("arst_illegal", O_illegal, 0);
    check("arst_tag", O_tag, 0);
    @(posedge I_clk); #2;
    I_rstn  = 1'b1;
    I_ready = 1'b1;
    #1;
    check("arst_ready_held", O_ready, 0);
    @(posedge I_clk); #2;
    check("arst_ready_back", O_ready, 1);
    @(posedge I_clk); #2;
    I_valid = 1'b0;
    check("arst_new_beat_tag", O_tag, 4'hB);
    wait_drain("drain_reset");

    repeat (2) @(posedge I_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
